ts_ep_packer: RTL

//   Byte-stream packer between the TS byte path (filter output) and the USB EP3 IN buffer of usb2_top.

---
 rtl/ts_ep_packer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ts_ep_packer.sv
`default_nettype none
// ============================================================================
// Module   : ts_ep_packer
// Purpose  : Skid-buffers TS bytes, writes them into the USB EP IN buffer and
//            commits full or idle-timed-out partial buffers.
// Revision : 1.0
// ============================================================================
module ts_ep_packer #(
    parameter int SKID_DEPTH    = 16,
    parameter int FLUSH_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    input  logic        ts_start,
    input  logic [10:0] commit_len,
    output logic [10:0] ep_buf_in_addr,
    output logic [7:0]  ep_buf_in_data,
    output logic        ep_buf_in_wren,
    input  logic        ep_buf_in_ready,
    output logic        ep_buf_in_commit,
    output logic [10:0] ep_buf_in_commit_len,
    input  logic        ep_buf_in_commit_ack,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam int c_AW = $clog2(SKID_DEPTH);
    localparam int c_IW = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [c_IW-1:0] c_TMO_LAST = c_IW'((FLUSH_TIMEOUT == 0) ? 0 : FLUSH_TIMEOUT - 1);
    localparam logic [c_AW:0]   c_PTR_ONE  = (c_AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [SKID_DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              r_discard;
    logic [10:0]       r_len;
    logic [10:0]       r_cnt;
    logic [c_IW-1:0]   r_idle;
    logic              r_wren;
    logic [10:0]       r_addr;
    logic [7:0]        r_data;
    logic              r_ovf;
    logic [15:0]       r_drop_cnt;

    logic w_full, w_empty, w_push, w_pop, w_drop, w_ovf, w_timeout, w_enter_fill;

    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Full is judged before any pop this cycle, so a pop never frees room for a same-cycle push.
    assign w_push  = ts_valid & ~w_full & (~r_discard | ts_start);
    assign w_ovf   = ts_valid &  w_full & (~r_discard | ts_start);
    assign w_drop  = ts_valid & ~w_push;
    assign w_pop   = (r_state == ST_FILL) & ~w_empty & (r_cnt != r_len);

    // r_idle holds cycles elapsed since the last pop, so the commit lands FLUSH_TIMEOUT cycles after it.
    assign w_timeout    = (FLUSH_TIMEOUT != 0) & w_empty & (r_cnt != 11'd0) & (r_idle >= c_TMO_LAST);
    assign w_enter_fill = (r_state == ST_IDLE) & (w_state_nxt == ST_FILL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (ep_buf_in_ready && !w_empty) w_state_nxt = ST_FILL;
            ST_FILL:   if ((r_wren && (r_cnt == r_len)) || w_timeout) w_state_nxt = ST_COMMIT;
            ST_COMMIT: if (ep_buf_in_commit_ack) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= ts_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_discard  <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_wren     <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= w_ovf;
            r_wren  <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

            if (ts_valid && w_full)        r_discard <= 1'b1;
            else if (ts_valid && ts_start) r_discard <= 1'b0;

            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

            if (w_pop) begin
                r_data <= r_mem[r_rd_ptr[c_AW-1:0]];
                r_addr <= r_cnt;
            end

            if (w_enter_fill) begin
                r_len  <= (commit_len == 11'd0) ? 11'd1 : commit_len;
                r_cnt  <= '0;
                r_idle <= '0;
            end else if (w_pop) begin
                r_cnt  <= r_cnt + 11'd1;
                r_idle <= c_IW'(1);
            end else if ((r_state == ST_FILL) && w_empty && (r_idle < c_TMO_LAST)) begin
                r_idle <= r_idle + c_IW'(1);
            end
        end
    end

    assign ep_buf_in_addr       = r_addr;
    assign ep_buf_in_data       = r_data;
    assign ep_buf_in_wren       = r_wren;
    assign ep_buf_in_commit     = (r_state == ST_COMMIT);
    assign ep_buf_in_commit_len = r_cnt;
    assign overflow             = r_ovf;
    assign drop_cnt             = r_drop_cnt;

endmodule
`default_nettype wire
